disp_share_arbiter: RTL and testbench

//  Shares the single 8-digit seven-segment scan display between N_REQ requesters
//  (e.g. PC, ALU result, register read-back, debug word). Round-robin arbitration,
//  a guaranteed minimum on-screen time per grant, and a frozen-value hold after
//  the holder releases. disp_data/disp_en drive the display scanner's data/enable

---
 rtl/disp_share_arbiter.sv | 122 ++++++++++++
 tb/tb_disp_share_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/disp_share_arbiter.sv
// Round-robin arbiter that shares one seven-segment scan display between N_REQ requesters.
// Each grant stays on screen for a minimum time. After release the last word stays frozen.
module disp_share_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 20_000_000,
  parameter int unsigned CNT_W       = 25,
  parameter logic [31:0] IDLE_DATA   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      grant,
  output logic [31:0]           disp_data,
  output logic                  disp_en,
  output logic                  busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShow, StHold} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] holder;

  logic [31:0]      words [N_REQ];
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] ptr_next;
  logic [N_REQ-1:0] win_onehot;
  logic             expired;
  logic             holder_req;
  logic             others;
  logic             do_grant;
  logic             go_idle;
  logic             go_hold;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = req_data[32*i +: 32];
  end

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[PTR_W'((int'(ptr) + k) % N_REQ)]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign ptr_next   = PTR_W'((int'(win) + 1) % N_REQ);
  assign win_onehot = N_REQ'(1) << win;
  assign expired    = (cnt == CNT_LAST);
  assign holder_req = req[holder];
  assign others     = |(req & ~grant);

  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
    go_hold  = 1'b0;
    unique case (state)
      StIdle: do_grant = found;
      StShow: begin
        if (expired) begin
          // With the holder still requesting, the ptr search reaches the holder last.
          if (holder_req) do_grant = others;
          else if (found) do_grant = 1'b1;
          else go_idle = 1'b1;
        end else if (!holder_req) begin
          go_hold = 1'b1;
        end
      end
      StHold: begin
        if (expired) begin
          do_grant = found;
          go_idle  = !found;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      grant     <= '0;
      disp_data <= IDLE_DATA;
      disp_en   <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      ptr       <= '0;
      holder    <= '0;
    end else if (do_grant) begin
      state     <= StShow;
      grant     <= win_onehot;
      holder    <= win;
      ptr       <= ptr_next;
      cnt       <= '0;
      disp_data <= words[win];
      disp_en   <= 1'b1;
      busy      <= 1'b1;
    end else if (go_idle) begin
      state     <= StIdle;
      grant     <= '0;
      disp_data <= IDLE_DATA;
      disp_en   <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      if (go_hold) state <= StHold;
      if (state != StIdle && !expired) cnt <= cnt + 1'b1;
      if (state == StShow && holder_req) disp_data <= words[holder];
    end
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter (N_REQ=4, HOLD_CYCLES=8).
// Expected outputs are queued per step and popped after the clock edge.
module tb_disp_share_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  d [4];
  logic [127:0] req_data;
  logic [3:0]   grant;
  logic [31:0]  disp_data;
  logic         disp_en;
  logic         busy;

  typedef struct {
    logic [3:0]  g;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  disp_share_arbiter #(
    .N_REQ      (4),
    .HOLD_CYCLES(8),
    .CNT_W      (4),
    .IDLE_DATA  (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .disp_data(disp_data),
    .disp_en  (disp_en),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, "/grant"}, 32'(grant), 32'(e.g));
    check({tag, "/data"}, disp_data, e.d);
    check({tag, "/en"}, 32'(disp_en), 32'(|e.g));
    check({tag, "/busy"}, 32'(busy), 32'(|e.g));
  endtask

  task automatic cyc(input string tag, input logic [3:0] g, input logic [31:0] dd);
    sb.push_back('{g: g, d: dd});
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  task automatic now_chk(input string tag, input logic [3:0] g, input logic [31:0] dd);
    sb.push_back('{g: g, d: dd});
    pop_compare(tag);
  endtask

  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};

    // Reset holds everything idle even with all requests raised.
    rst = 1'b1;
    req = 4'hF;
    d[0] = 32'h1234_5678; d[1] = 32'h1111_1111; d[2] = 32'h2222_2222; d[3] = 32'h3333_3333;
    repeat (3) @(posedge clk);
    #1;
    now_chk("rst", 4'b0000, 32'h0);
    rst = 1'b0;
    req = 4'h0;
    repeat (3) cyc("idle", 4'b0000, 32'h0);

    // Single grant with live data tracking.
    req = 4'b0001;
    cyc("grant0", 4'b0001, 32'h1234_5678);
    d[0] = 32'h1234_5679;
    cyc("live0", 4'b0001, 32'h1234_5679);

    // Release before expiry: frozen word, holder re-request ignored, idle after 8 cycles.
    req = 4'b0000;
    d[0] = 32'hDEAD_BEEF;
    repeat (2) cyc("hold", 4'b0001, 32'h1234_5679);
    req = 4'b0001;
    d[0] = 32'hCAFE_F00D;
    repeat (2) cyc("hold_rereq", 4'b0001, 32'h1234_5679);
    req = 4'b0000;
    repeat (2) cyc("hold_end", 4'b0001, 32'h1234_5679);
    cyc("to_idle", 4'b0000, 32'h0);
    cyc("idle2", 4'b0000, 32'h0);

    // Fresh pointer, then all four request: 8 cycles each in rotation.
    rst = 1'b1;
    #2;
    now_chk("rst_pulse", 4'b0000, 32'h0);
    rst = 1'b0;
    d[0] = 32'hA0A0_0000; d[1] = 32'hA1A1_0001; d[2] = 32'hA2A2_0002; d[3] = 32'hA3A3_0003;
    req = 4'hF;
    foreach (ord[k]) begin
      for (int j = 0; j < 8; j++) cyc("rr", 4'(1 << ord[k]), d[ord[k]]);
    end

    // Slot 2 alone keeps the display past expiry; slot 0 then wins via wrap from ptr=3.
    req = 4'b0100;
    for (int j = 0; j < 20; j++) cyc("alone2", 4'b0100, 32'hA2A2_0002);
    req = 4'b0101;
    for (int j = 0; j < 8; j++) cyc("wrap0", 4'b0001, 32'hA0A0_0000);
    cyc("back2", 4'b0100, 32'hA2A2_0002);
    cyc("show2", 4'b0100, 32'hA2A2_0002);

    // Asynchronous reset between edges, then arbitration restarts from slot 0.
    #3;
    rst = 1'b1;
    #1;
    now_chk("rst_async", 4'b0000, 32'h0);
    #1;
    rst = 1'b0;
    req = 4'b1010;
    cyc("after_rst", 4'b0010, 32'hA1A1_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
